// File: rtl/src_sched_pkg.sv
// Shared constants for the source scheduler: widths, frontpanel
// endpoint addresses and the power-up source enable mask.
package src_sched_pkg;

    localparam int N_SRC     = 8;
    localparam int W_SRC     = 5;
    localparam int W_DATA    = 18;
    localparam int W_WR_ADDR = 16;
    localparam int W_WR_DATA = 48;
    localparam int W_IDX     = $clog2(N_SRC);

    // Frontpanel endpoint map for this block.
    localparam logic [W_WR_ADDR-1:0] SRC_EN_ADDR      = 16'h0040;
    localparam logic [W_WR_ADDR-1:0] SRC_OVF_CLR_ADDR = 16'h0041;

    // All sources enabled out of reset.
    localparam logic [N_SRC-1:0] SRC_EN_INIT = '1;

    // Zero-extend an internal source index to the output index width.
    function automatic logic [W_SRC-1:0] idx_to_src(input logic [W_IDX-1:0] idx);
        return W_SRC'(idx);
    endfunction

endpackage

// File: rtl/src_sched_if.sv
// Sample-stream bundle between the ADC front ends, the scheduler and the
// downstream dispatch buffer.  The slave side is the scheduler itself.
interface src_sched_if;
    import src_sched_pkg::*;

    logic [N_SRC-1:0]        src_dv_in;
    logic [N_SRC*W_DATA-1:0] src_data_in;
    logic                    ready_in;
    logic                    dv_out;
    logic [W_SRC-1:0]        src_out;
    logic [W_DATA-1:0]       data_out;

    modport slave (
        input  src_dv_in,
        input  src_data_in,
        input  ready_in,
        output dv_out,
        output src_out,
        output data_out
    );

    modport master (
        output src_dv_in,
        output src_data_in,
        output ready_in,
        input  dv_out,
        input  src_out,
        input  data_out
    );

endinterface

// File: rtl/src_sched_rr_pick.sv
// Rotating-priority picker: returns the first set request bit scanning
// upward from ptr+1, wrapping modulo N.  Purely combinational.
module rr_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    localparam logic [W:0] N_W = (W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     base;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // Rotate the request vector so bit 0 is the slot just after ptr.
    assign dbl  = {req, req};
    assign base = {1'b0, ptr} + (W+1)'(1);
    assign rot  = dbl[base +: N];

    // Lowest set bit of the rotated vector is the winner's offset.
    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = W'(k);
            end
        end
    end

    // Map the offset back to an absolute index, wrapping once.
    always_comb begin
        sum   = base + {1'b0, off};
        found = |req;
        if (sum >= N_W) begin
            index = W'(sum - N_W);
        end else begin
            index = W'(sum);
        end
    end

endmodule

// File: rtl/src_sched.sv
// Round-robin merge of N_SRC one-deep sample holders into a single
// (dv, src, data) stream, with frontpanel-controlled enables and sticky
// per-source overflow flags.
module src_sched
    import src_sched_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    src_sched_if.slave           bus,
    input  logic                 wr_en,
    input  logic [W_WR_ADDR-1:0] wr_addr,
    input  logic [W_WR_DATA-1:0] wr_data,
    output logic [N_SRC-1:0]     ovf_out,
    output logic [N_SRC-1:0]     pend_out
);

    logic [N_SRC-1:0]  src_en_reg;
    logic [N_SRC-1:0]  src_en_next;
    logic [N_SRC-1:0]  pend_reg;
    logic [N_SRC-1:0]  pend_next;
    logic [N_SRC-1:0]  ovf_reg;
    logic [N_SRC-1:0]  ovf_next;
    logic [N_SRC-1:0]  ovf_clr;
    logic [N_SRC-1:0]  ovf_evt;
    logic [N_SRC-1:0]  cap;
    logic [N_SRC-1:0]  granted;
    logic [N_SRC-1:0]  elig;
    logic [W_IDX-1:0]  ptr_reg;
    logic [W_DATA-1:0] hold_reg [N_SRC];

    logic              dv_reg;
    logic [W_SRC-1:0]  src_reg;
    logic [W_DATA-1:0] data_reg;

    logic              pick_found;
    logic [W_IDX-1:0]  pick_idx;
    logic              grant_valid;

    logic              wr_src_en;
    logic              wr_ovf_clr;

    // Arbitration uses the enable mask as it stood before this edge, so a
    // grant computed alongside a disable write still issues.
    assign elig = pend_reg & src_en_reg;

    rr_pick #(
        .N (N_SRC),
        .W (W_IDX)
    ) u_pick (
        .req   (elig),
        .ptr   (ptr_reg),
        .found (pick_found),
        .index (pick_idx)
    );

    assign grant_valid = bus.ready_in && pick_found;

    // Frontpanel decode; writes take effect on the write edge.
    always_comb begin
        wr_src_en   = wr_en && (wr_addr == SRC_EN_ADDR);
        wr_ovf_clr  = wr_en && (wr_addr == SRC_OVF_CLR_ADDR);
        src_en_next = wr_src_en  ? wr_data[N_SRC-1:0] : src_en_reg;
        ovf_clr     = wr_ovf_clr ? wr_data[N_SRC-1:0] : '0;
    end

    // Per-source capture, pending and overflow bookkeeping.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign cap[gi]     = bus.src_dv_in[gi] && src_en_reg[gi];
        assign granted[gi] = grant_valid && (pick_idx == W_IDX'(gi));

        // A capture landing on an unissued sample is an overflow; a
        // capture on the grant edge simply refills the slot.
        assign ovf_evt[gi] = cap[gi] && pend_reg[gi] && !granted[gi];

        // Disable wins, then a fresh capture, then the grant clears.
        assign pend_next[gi] = !src_en_next[gi] ? 1'b0 :
                               cap[gi]          ? 1'b1 :
                               granted[gi]      ? 1'b0 : pend_reg[gi];

        // Overflow set has priority over a same-edge clear.
        assign ovf_next[gi] = (ovf_reg[gi] && !ovf_clr[gi]) || ovf_evt[gi];

        // Holding register: latest accepted sample wins.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                hold_reg[gi] <= '0;
            end else if (cap[gi]) begin
                hold_reg[gi] <= bus.src_data_in[gi*W_DATA +: W_DATA];
            end
        end
    end

    // Status and control registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            src_en_reg <= SRC_EN_INIT;
            pend_reg   <= '0;
            ovf_reg    <= '0;
        end else begin
            src_en_reg <= src_en_next;
            pend_reg   <= pend_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Output register and round-robin pointer; ptr resets to the last
    // slot so source 0 has first priority.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dv_reg   <= 1'b0;
            src_reg  <= '0;
            data_reg <= '0;
            ptr_reg  <= W_IDX'(N_SRC - 1);
        end else if (grant_valid) begin
            dv_reg   <= 1'b1;
            src_reg  <= idx_to_src(pick_idx);
            data_reg <= hold_reg[pick_idx];
            ptr_reg  <= pick_idx;
        end else begin
            dv_reg   <= 1'b0;
        end
    end

    assign bus.dv_out   = dv_reg;
    assign bus.src_out  = src_reg;
    assign bus.data_out = data_reg;
    assign ovf_out      = ovf_reg;
    assign pend_out     = pend_reg;

endmodule

// File: tb/tb_src_sched.sv
// Directed testbench for src_sched: reset, round-robin fairness, single
// sample latency, backpressure/overflow, same-edge refill, back-to-back
// single source, disable, and asynchronous reset mid-operation.
module tb_src_sched;
    import src_sched_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 wr_en;
    logic [W_WR_ADDR-1:0] wr_addr;
    logic [W_WR_DATA-1:0] wr_data;
    logic [N_SRC-1:0]     ovf;
    logic [N_SRC-1:0]     pend;

    int vecs;
    int miss;

    src_sched_if bus ();

    src_sched dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ovf_out  (ovf),
        .pend_out (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int s, input logic [W_DATA-1:0] d);
        bus.src_dv_in[s] = 1'b1;
        bus.src_data_in[s*W_DATA +: W_DATA] = d;
    endtask

    task automatic fp_write(input logic [W_WR_ADDR-1:0] a, input logic [W_WR_DATA-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] got;
        rst_n = 1'b0;
        bus.ready_in  = 1'b1;
        bus.src_dv_in = '1;
        repeat (3) step();
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if (got !== 24'h0) begin
            miss++; $display("FAIL reset_out: got %h want %h", got, 24'h0);
        end else $display("vec %0d reset_out ok", vecs);
        vecs++;
        if ({pend, ovf} !== 16'h0) begin
            miss++; $display("FAIL reset_flags: got %h want %h", {pend, ovf}, 16'h0);
        end else $display("vec %0d reset_flags ok", vecs);
        bus.src_dv_in = '0;
        rst_n = 1'b1;
        step();
        vecs++;
        if ({bus.dv_out, pend} !== 9'h0) begin
            miss++; $display("FAIL reset_release: got %h want %h", {bus.dv_out, pend}, 9'h0);
        end else $display("vec %0d reset_release ok", vecs);
        // ptr=7 after reset: source 0 must beat source 7.
        put(0, 18'h0AAAA);
        put(7, 18'h15555);
        step();
        bus.src_dv_in = '0;
        vecs++;
        if (pend !== 8'h81) begin
            miss++; $display("FAIL reset_pend: got %h want %h", pend, 8'h81);
        end else $display("vec %0d reset_pend ok", vecs);
        step();
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if (got !== {1'b1, 5'd0, 18'h0AAAA}) begin
            miss++; $display("FAIL reset_first: got %h want %h", got, {1'b1, 5'd0, 18'h0AAAA});
        end else $display("vec %0d reset_first ok", vecs);
        step();
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if (got !== {1'b1, 5'd7, 18'h15555}) begin
            miss++; $display("FAIL reset_second: got %h want %h", got, {1'b1, 5'd7, 18'h15555});
        end else $display("vec %0d reset_second ok", vecs);
        step();
    endtask

    task automatic test_fairness(input logic [W_DATA-1:0] base);
        logic [23:0] got;
        logic [23:0] exp;
        for (int s = 0; s < N_SRC; s++) put(s, base + W_DATA'(s));
        step();
        bus.src_dv_in = '0;
        vecs++;
        if (pend !== 8'hFF) begin
            miss++; $display("FAIL fair_pend: got %h want %h", pend, 8'hFF);
        end else $display("vec %0d fair_pend ok", vecs);
        for (int c = 0; c < N_SRC; c++) begin
            step();
            got = {bus.dv_out, bus.src_out, bus.data_out};
            exp = {1'b1, 5'(c), base + W_DATA'(c)};
            vecs++;
            if (got !== exp) begin
                miss++; $display("FAIL fair_word%0d: got %h want %h", c, got, exp);
            end else $display("vec %0d fair_word%0d ok", vecs, c);
        end
        step();
        got = {bus.dv_out, bus.src_out, bus.data_out};
        exp = {1'b0, 5'd7, base + W_DATA'(7)};
        vecs++;
        if ({got, pend} !== {exp, 8'h00}) begin
            miss++; $display("FAIL fair_idle: got %h want %h", {got, pend}, {exp, 8'h00});
        end else $display("vec %0d fair_idle ok", vecs);
    endtask

    task automatic test_single();
        logic [23:0] got;
        put(3, 18'h2A5A);
        step();
        bus.src_dv_in = '0;
        vecs++;
        if ({bus.dv_out, pend} !== {1'b0, 8'h08}) begin
            miss++; $display("FAIL single_cap: got %h want %h", {bus.dv_out, pend}, {1'b0, 8'h08});
        end else $display("vec %0d single_cap ok", vecs);
        step();
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if ({got, pend} !== {1'b1, 5'd3, 18'h2A5A, 8'h00}) begin
            miss++; $display("FAIL single_word: got %h want %h", {got, pend}, {1'b1, 5'd3, 18'h2A5A, 8'h00});
        end else $display("vec %0d single_word ok", vecs);
        step();
        vecs++;
        if (bus.dv_out !== 1'b0) begin
            miss++; $display("FAIL single_once: got %b want 0", bus.dv_out);
        end else $display("vec %0d single_once ok", vecs);
    endtask

    task automatic test_backpressure();
        logic [23:0] got;
        bus.ready_in = 1'b0;
        put(5, 18'h00001);
        step();
        put(5, 18'h00002);
        step();
        bus.src_dv_in = '0;
        vecs++;
        if ({bus.dv_out, pend, ovf} !== {1'b0, 8'h20, 8'h20}) begin
            miss++; $display("FAIL bp_ovf: got %h want %h", {bus.dv_out, pend, ovf}, {1'b0, 8'h20, 8'h20});
        end else $display("vec %0d bp_ovf ok", vecs);
        step();
        vecs++;
        if ({bus.dv_out, pend} !== {1'b0, 8'h20}) begin
            miss++; $display("FAIL bp_hold: got %h want %h", {bus.dv_out, pend}, {1'b0, 8'h20});
        end else $display("vec %0d bp_hold ok", vecs);
        bus.ready_in = 1'b1;
        step();
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if (got !== {1'b1, 5'd5, 18'h00002}) begin
            miss++; $display("FAIL bp_word: got %h want %h", got, {1'b1, 5'd5, 18'h00002});
        end else $display("vec %0d bp_word ok", vecs);
        step();
        vecs++;
        if ({bus.dv_out, ovf} !== {1'b0, 8'h20}) begin
            miss++; $display("FAIL bp_once: got %h want %h", {bus.dv_out, ovf}, {1'b0, 8'h20});
        end else $display("vec %0d bp_once ok", vecs);
        fp_write(16'h0041, 48'h20);
        vecs++;
        if (ovf !== 8'h00) begin
            miss++; $display("FAIL bp_clr: got %h want %h", ovf, 8'h00);
        end else $display("vec %0d bp_clr ok", vecs);
    endtask

    task automatic test_same_edge();
        logic [23:0] got;
        put(2, 18'h11111);
        step();
        put(2, 18'h22222);
        step();
        bus.src_dv_in = '0;
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if ({got, pend, ovf} !== {1'b1, 5'd2, 18'h11111, 8'h04, 8'h00}) begin
            miss++; $display("FAIL same_old: got %h want %h", {got, pend, ovf}, {1'b1, 5'd2, 18'h11111, 8'h04, 8'h00});
        end else $display("vec %0d same_old ok", vecs);
        step();
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if ({got, pend} !== {1'b1, 5'd2, 18'h22222, 8'h00}) begin
            miss++; $display("FAIL same_new: got %h want %h", {got, pend}, {1'b1, 5'd2, 18'h22222, 8'h00});
        end else $display("vec %0d same_new ok", vecs);
        step();
    endtask

    task automatic test_back_to_back();
        logic [23:0] got;
        logic [23:0] exp;
        put(4, 18'h00040);
        step();
        for (int n = 1; n <= 4; n++) begin
            if (n < 4) put(4, 18'h00040 + W_DATA'(n));
            else bus.src_dv_in = '0;
            step();
            got = {bus.dv_out, bus.src_out, bus.data_out};
            exp = {1'b1, 5'd4, 18'h00040 + W_DATA'(n - 1)};
            vecs++;
            if ({got, ovf} !== {exp, 8'h00}) begin
                miss++; $display("FAIL b2b_word%0d: got %h want %h", n, {got, ovf}, {exp, 8'h00});
            end else $display("vec %0d b2b_word%0d ok", vecs, n);
        end
        step();
    endtask

    task automatic test_disable();
        logic [23:0] got;
        bus.ready_in = 1'b0;
        put(0, 18'h3FFFF);
        step();
        bus.src_dv_in = '0;
        vecs++;
        if (pend !== 8'h01) begin
            miss++; $display("FAIL dis_pend: got %h want %h", pend, 8'h01);
        end else $display("vec %0d dis_pend ok", vecs);
        fp_write(16'h0040, 48'hFE);
        vecs++;
        if (pend !== 8'h00) begin
            miss++; $display("FAIL dis_clear: got %h want %h", pend, 8'h00);
        end else $display("vec %0d dis_clear ok", vecs);
        bus.ready_in = 1'b1;
        step();
        vecs++;
        if (bus.dv_out !== 1'b0) begin
            miss++; $display("FAIL dis_noout: got %b want 0", bus.dv_out);
        end else $display("vec %0d dis_noout ok", vecs);
        put(0, 18'h01234);
        put(1, 18'h05678);
        step();
        bus.src_dv_in = '0;
        vecs++;
        if (pend !== 8'h02) begin
            miss++; $display("FAIL dis_ignore: got %h want %h", pend, 8'h02);
        end else $display("vec %0d dis_ignore ok", vecs);
        step();
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if (got !== {1'b1, 5'd1, 18'h05678}) begin
            miss++; $display("FAIL dis_other: got %h want %h", got, {1'b1, 5'd1, 18'h05678});
        end else $display("vec %0d dis_other ok", vecs);
        fp_write(16'h0040, 48'hFF);
    endtask

    task automatic test_reset_mid();
        logic [23:0] got;
        bus.ready_in = 1'b0;
        put(6, 18'h06666);
        step();
        bus.src_dv_in = '0;
        vecs++;
        if (pend !== 8'h40) begin
            miss++; $display("FAIL mid_pend: got %h want %h", pend, 8'h40);
        end else $display("vec %0d mid_pend ok", vecs);
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus.dv_out, bus.src_out, bus.data_out};
        vecs++;
        if ({got, pend, ovf} !== 40'h0) begin
            miss++; $display("FAIL mid_reset: got %h want %h", {got, pend, ovf}, 40'h0);
        end else $display("vec %0d mid_reset ok", vecs);
        bus.ready_in = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        vecs++;
        if ({bus.dv_out, pend} !== 9'h0) begin
            miss++; $display("FAIL mid_after: got %h want %h", {bus.dv_out, pend}, 9'h0);
        end else $display("vec %0d mid_after ok", vecs);
    endtask

    initial begin
        vecs = 0;
        miss = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        bus.src_dv_in = '0;
        bus.src_data_in = '0;
        bus.ready_in = 1'b0;
        test_reset();
        test_fairness(18'h00100);
        test_fairness(18'h00200);
        test_single();
        test_backpressure();
        test_same_edge();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
